npu_loop_sequencer: RTL
=======================

# npu_loop_sequencer

Sequencer that drives the NPU datapath through one layer's nested loop schedule. On `start` it latches the per-layer loop bounds (KSI, CKG, L0..L4) presented by the layer configuration decoder. It then walks a six-level counter nest, issuing one index tuple per accepted beat over a valid/ready handshake, and pulses `done` after the final beat. It sits between the layer-opcode configuration decoder and the PE-array/buffer address logic.

## Interface
- `W`, 8, NPU array dimension (PE rows/cols)
- `CLOG2K`, 3, width of kernel-sweep bound/index
- `CLOG2W`, 3, width of CKG bound
- `CLOG2L`, 6, width of L0..L4 bounds/indices

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  synchronous active-low reset
- `start`  in  1  begin layer; sampled only in IDLE
- `arv_KSI`  in  CLOG2K  kernel-sweep bound (last index, inclusive)
- `arv_CKG`  in  CLOG2W  active PE rows minus 1
- `arv_L0`..`arv_L4`  in  CLOG2L each  loop bounds (last index, inclusive)
- `step_ready`  in  1  datapath accepts current beat
- `step_valid`  out  1  index tuple valid
- `idx_k`  out  CLOG2K  kernel-sweep index
- `idx_l0`..`idx_l4`  out  CLOG2L each  loop indices
- `acc_first`  out  1  beat is first of an accumulation group (idx_k==0 && idx_l0==0)
- `acc_last`  out  1  beat is last of an accumulation group (idx_k==KSI && idx_l0==L0)
- `row_en`  out  W  thermometer PE-row enable, bit i = (i <= latched CKG)
- `busy`  out  1  high in LOAD and RUN
- `done`  out  1  one-cycle pulse after final beat

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: `start`=1 → capture all `arv_*` into shadow registers → LOAD. Bound inputs are ignored after capture.
- LOAD: clear all indices to 0 → RUN (one cycle).
- RUN: `step_valid`=1. A beat is accepted when `step_valid && step_ready`.
- Nest order, innermost first: k, l0, l1, l2, l3, l4.
- On accept, the innermost index increments. An index equal to its bound wraps to 0 and carries into the next level.
- Final beat: all indices equal their bounds. Accepting it → DONE with indices held. DONE lasts one cycle (`done`=1) → IDLE.
- All-zero bounds give exactly one beat. Total beats = (KSI+1)(L0+1)(L1+1)(L2+1)(L3+1)(L4+1).
- `step_ready`=0 holds indices and `step_valid` stable. No beat is ever dropped or duplicated.
- `start` outside IDLE is ignored, including `start` in the same cycle as `done`.
- `row_en` derives from the shadow CKG and holds its value until the next capture.
- Arithmetic: indices are unsigned, compared for equality only. No index ever exceeds its bound.

## Timing
- Reset (`rst_n`=0 at a clock edge): state IDLE; all indices 0; `step_valid`, `busy`, `done`, `acc_first`, `acc_last` = 0; `row_en`=0.
- Reset mid-RUN aborts on the same edge. Recovery requires a fresh `start`.
- `start` at edge N: LOAD in cycle N+1; first `step_valid` in cycle N+2.
- Throughput: one beat per cycle while `step_ready`=1.
- Final beat accepted at edge M: `done`=1 and `step_valid`=0 in cycle M+1. IDLE in cycle M+2, where a new `start` is accepted.
- All outputs are registered or decoded from registers only. There is no combinational path from `step_ready` or `start` to any output.

## Configuration
- `NPU_SEQ_PERF_EN` defined adds two ports:
  - `perf_run_cycles`  out  32  count of cycles in RUN
  - `perf_stall_cycles`  out  32  count of RUN cycles with `step_ready`=0
- Both counters clear in LOAD, saturate at 2^32-1, hold after DONE, and reset to 0.
- Not defined: ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- Single beat: all bounds 0, `step_ready`=1. Expect `start` → one beat at cycle +2 with `acc_first`=`acc_last`=1 → `done` at +3 → IDLE at +4.
- Full nest: KSI=2, L0=1, L1=2, L2=0, L3=1, L4=1, `step_ready`=1. Expect 72 beats in strict innermost-first order, `acc_last` on every 6th beat, and `done` exactly once.
- Backpressure: bounds KSI=1, L0=3, others 0; `step_ready` toggles pseudo-randomly. Expect indices stable while stalled, all 8 tuples delivered once each, and `perf_stall_cycles` equal to the bench's count of stall cycles.
- `row_en`: CKG=0 → 8'h01; CKG=2 → 8'h07; CKG=7 → 8'hFF. Changing `arv_CKG` mid-RUN leaves `row_en` unchanged.
- Ignored start: pulse `start` during RUN and again in the `done` cycle. Expect no restart and no extra beats; the next `start` in IDLE is accepted.
- Reset mid-RUN: assert `rst_n`=0 after 5 beats. Expect all outputs at reset values next cycle and no `done`; a subsequent `start` runs the full schedule from index 0.

Source files
------------

// File: rtl/npu_loop_sequencer.sv
// npu_loop_sequencer
// Walks one layer's six-level loop nest (k, l0, l1, l2, l3, l4; innermost
// first) and issues one index tuple per accepted beat.
// Optional build macro: NPU_SEQ_PERF_EN adds RUN-cycle and stall-cycle
// performance counters (perf_run_cycles, perf_stall_cycles).
//
// Handshake: a beat transfers on a rising edge where step_valid && step_ready.
// step_valid is high in every RUN cycle. While step_ready is low, step_valid
// and the index tuple hold. step_valid never depends combinationally on
// step_ready.
module npu_loop_sequencer #(
  parameter int W      = 8,
  parameter int CLOG2K = 3,
  parameter int CLOG2W = 3,
  parameter int CLOG2L = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CLOG2K-1:0] arv_KSI,
  input  logic [CLOG2W-1:0] arv_CKG,
  input  logic [CLOG2L-1:0] arv_L0,
  input  logic [CLOG2L-1:0] arv_L1,
  input  logic [CLOG2L-1:0] arv_L2,
  input  logic [CLOG2L-1:0] arv_L3,
  input  logic [CLOG2L-1:0] arv_L4,
  input  logic              step_ready,
  output logic              step_valid,
  output logic [CLOG2K-1:0] idx_k,
  output logic [CLOG2L-1:0] idx_l0,
  output logic [CLOG2L-1:0] idx_l1,
  output logic [CLOG2L-1:0] idx_l2,
  output logic [CLOG2L-1:0] idx_l3,
  output logic [CLOG2L-1:0] idx_l4,
  output logic              acc_first,
  output logic              acc_last,
  output logic [W-1:0]      row_en,
  output logic              busy,
  output logic              done,
  output logic [1:0]        fsm_state
`ifdef NPU_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_run_cycles,
  output logic [31:0]       perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CLOG2K-1:0] K_ONE = 1;
  localparam logic [CLOG2L-1:0] L_ONE = 1;

  state_t state, state_next;

  // Shadow copies of the layer bounds, captured on start.
  logic [CLOG2K-1:0] ksi_q;
  logic [CLOG2L-1:0] l0_q, l1_q, l2_q, l3_q, l4_q;
  logic [W-1:0]      row_en_q;
  logic [W-1:0]      row_therm;

  logic wrap_k, wrap_l0, wrap_l1, wrap_l2, wrap_l3, wrap_l4;
  logic carry_l0, carry_l1, carry_l2, carry_l3, carry_l4;
  logic last_beat, accept;

  assign accept    = (state == RUN) && step_ready;

  assign wrap_k    = (idx_k  == ksi_q);
  assign wrap_l0   = (idx_l0 == l0_q);
  assign wrap_l1   = (idx_l1 == l1_q);
  assign wrap_l2   = (idx_l2 == l2_q);
  assign wrap_l3   = (idx_l3 == l3_q);
  assign wrap_l4   = (idx_l4 == l4_q);

  // carry_lN: every level inside lN is at its bound, so lN advances.
  assign carry_l0  = wrap_k;
  assign carry_l1  = carry_l0 && wrap_l0;
  assign carry_l2  = carry_l1 && wrap_l1;
  assign carry_l3  = carry_l2 && wrap_l2;
  assign carry_l4  = carry_l3 && wrap_l3;
  assign last_beat = carry_l4 && wrap_l4;

  // Thermometer decode of the incoming CKG: bit i set when i <= CKG.
  always_comb begin
    row_therm = '0;
    for (int i = 0; i < W; i++) begin
      row_therm[i] = (i <= int'(arv_CKG));
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = RUN;
      RUN:     if (accept && last_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bound capture, index clear and the counter nest.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ksi_q    <= '0;
      l0_q     <= '0;
      l1_q     <= '0;
      l2_q     <= '0;
      l3_q     <= '0;
      l4_q     <= '0;
      row_en_q <= '0;
      idx_k    <= '0;
      idx_l0   <= '0;
      idx_l1   <= '0;
      idx_l2   <= '0;
      idx_l3   <= '0;
      idx_l4   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ksi_q    <= arv_KSI;
            l0_q     <= arv_L0;
            l1_q     <= arv_L1;
            l2_q     <= arv_L2;
            l3_q     <= arv_L3;
            l4_q     <= arv_L4;
            row_en_q <= row_therm;
          end
        end
        LOAD: begin
          idx_k  <= '0;
          idx_l0 <= '0;
          idx_l1 <= '0;
          idx_l2 <= '0;
          idx_l3 <= '0;
          idx_l4 <= '0;
        end
        RUN: begin
          // The final beat leaves the indices at their bounds for DONE.
          if (accept && !last_beat) begin
            idx_k <= wrap_k ? '0 : idx_k + K_ONE;
            if (carry_l0) idx_l0 <= wrap_l0 ? '0 : idx_l0 + L_ONE;
            if (carry_l1) idx_l1 <= wrap_l1 ? '0 : idx_l1 + L_ONE;
            if (carry_l2) idx_l2 <= wrap_l2 ? '0 : idx_l2 + L_ONE;
            if (carry_l3) idx_l3 <= wrap_l3 ? '0 : idx_l3 + L_ONE;
            if (carry_l4) idx_l4 <= wrap_l4 ? '0 : idx_l4 + L_ONE;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef NPU_SEQ_PERF_EN
  // Saturating RUN-cycle and stall-cycle counters, cleared in LOAD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_run_cycles   <= '0;
      perf_stall_cycles <= '0;
    end else if (state == LOAD) begin
      perf_run_cycles   <= '0;
      perf_stall_cycles <= '0;
    end else if (state == RUN) begin
      if (perf_run_cycles != 32'hFFFF_FFFF)
        perf_run_cycles <= perf_run_cycles + 32'd1;
      if (!step_ready && perf_stall_cycles != 32'hFFFF_FFFF)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

  // Outputs decode from registered state and indices only.
  assign step_valid = (state == RUN);
  assign busy       = (state == LOAD) || (state == RUN);
  assign done       = (state == DONE);
  assign acc_first  = step_valid && (idx_k == '0) && (idx_l0 == '0);
  assign acc_last   = step_valid && wrap_k && wrap_l0;
  assign row_en     = row_en_q;
  assign fsm_state  = state;

endmodule
